// File: rtl/mmio_pkg.sv
// mmio_pkg: register map shared by the MMIO responder,
// data_mem and the CPU bench.
package mmio_pkg;

   localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h8000_0000;

   localparam logic [4:0] OFF_LED     = 5'h00;
   localparam logic [4:0] OFF_SW      = 5'h04;
   localparam logic [4:0] OFF_SW_EDGE = 5'h08;
   localparam logic [4:0] OFF_CYCLE   = 5'h0C;
   localparam logic [4:0] OFF_TCMP    = 5'h10;
   localparam logic [4:0] OFF_TCNT    = 5'h14;
   localparam logic [4:0] OFF_TCTRL   = 5'h18;
   localparam logic [4:0] OFF_RSVD    = 5'h1C;

   localparam int TCTRL_EN     = 0;
   localparam int TCTRL_PEND   = 1;
   localparam int TCTRL_AUTO   = 2;
   localparam int TCTRL_IRQ_EN = 3;

   localparam logic [31:0] TCMP_RESET = 32'hFFFF_FFFF;

   // Word index inside the window, addr[4:2].
   typedef enum logic [2:0] {
      REG_LED     = 3'd0,
      REG_SW      = 3'd1,
      REG_SW_EDGE = 3'd2,
      REG_CYCLE   = 3'd3,
      REG_TCMP    = 3'd4,
      REG_TCNT    = 3'd5,
      REG_TCTRL   = 3'd6,
      REG_RSVD    = 3'd7
   } reg_sel_e;

   // Field order matches the TCTRL bit indices above.
   typedef struct packed {
      logic irq_en;
      logic autoreload;
      logic pend;
      logic en;
   } tctrl_t;

   function automatic logic [31:0] tctrl_word(input tctrl_t t);
      return {28'h0, t};
   endfunction

endpackage

// File: rtl/mmio_responder_sync_edge_detect.sv
// sync_edge_detect: two-flop synchroniser for async inputs,
// plus a history flop for rising-edge pulses.
module sync_edge_detect #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] async_in,
   output logic [W-1:0] sync_out,
   output logic [W-1:0] rise
);

   logic [W-1:0] meta_q, meta_d;
   logic [W-1:0] sync_q, sync_d;
   logic [W-1:0] hist_q, hist_d;

   // Shift chain: pin -> meta -> sync -> hist.
   always_comb begin
      meta_d = async_in;
      sync_d = meta_q;
      hist_d = sync_q;
   end

   // Chain flops, cleared asynchronously.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_q <= '0;
         sync_q <= '0;
         hist_q <= '0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         hist_q <= hist_d;
      end
   end

   assign sync_out = sync_q;
   assign rise     = sync_q & ~hist_q;

endmodule

// File: rtl/mmio_responder.sv
// mmio_responder: data-port MMIO target with LEDs, switches,
// cycle counter and compare timer. BASE_ADDR must be 32B aligned.
module mmio_responder
   import mmio_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = MMIO_BASE_DEFAULT,
   parameter int          LED_W     = 8,
   parameter int          SW_W      = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             memwrite,
   input  logic             memread,
   input  logic [31:0]      addr,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic             hit,
   input  logic [SW_W-1:0]  switch_input,
   output logic [LED_W-1:0] led_output,
   output logic             irq
);

   reg_sel_e         sel;
   logic             wr_en;
   logic             rd_en;
   logic             wr_led;
   logic             wr_sw_edge;
   logic             wr_tcmp;
   logic             wr_tcnt;
   logic             wr_tctrl;
   logic             tmr_match;

   logic [SW_W-1:0]  sw_sync;
   logic [SW_W-1:0]  sw_rise;

   logic [LED_W-1:0] led_q, led_d;
   logic [SW_W-1:0]  sw_edge_q, sw_edge_d;
   logic [31:0]      cycle_q, cycle_d;
   logic [31:0]      tcmp_q, tcmp_d;
   logic [31:0]      tcnt_q, tcnt_d;
   tctrl_t           tctrl_q, tctrl_d;

   sync_edge_detect #(
      .W (SW_W)
   ) u_sw (
      .clk      (clk),
      .reset    (reset),
      .async_in (switch_input),
      .sync_out (sw_sync),
      .rise     (sw_rise)
   );

   // Window decode; the strobes do not affect hit.
   always_comb begin
      hit   = (addr[31:5] == BASE_ADDR[31:5])
              && (addr[1:0] == 2'b00);
      sel   = reg_sel_e'(addr[4:2]);
      wr_en = memwrite & hit;
      rd_en = memread & hit;
   end

   // Per-register write strobes; RO and reserved slots drop writes.
   always_comb begin
      wr_led     = 1'b0;
      wr_sw_edge = 1'b0;
      wr_tcmp    = 1'b0;
      wr_tcnt    = 1'b0;
      wr_tctrl   = 1'b0;
      if (wr_en) begin
         unique case (sel)
            REG_LED:     wr_led     = 1'b1;
            REG_SW_EDGE: wr_sw_edge = 1'b1;
            REG_TCMP:    wr_tcmp    = 1'b1;
            REG_TCNT:    wr_tcnt    = 1'b1;
            REG_TCTRL:   wr_tctrl   = 1'b1;
            default:     ;
         endcase
      end
   end

   // Zero-latency read mux over pre-edge register state.
   always_comb begin
      readdata = 32'h0;
      if (rd_en) begin
         unique case (sel)
            REG_LED:     readdata = 32'(led_q);
            REG_SW:      readdata = 32'(sw_sync);
            REG_SW_EDGE: readdata = 32'(sw_edge_q);
            REG_CYCLE:   readdata = cycle_q;
            REG_TCMP:    readdata = tcmp_q;
            REG_TCNT:    readdata = tcnt_q;
            REG_TCTRL:   readdata = tctrl_word(tctrl_q);
            REG_RSVD:    readdata = 32'h0;
         endcase
      end
   end

   // LED, compare value and free-running cycle counter.
   always_comb begin
      led_d   = wr_led  ? writedata[LED_W-1:0] : led_q;
      tcmp_d  = wr_tcmp ? writedata : tcmp_q;
      cycle_d = cycle_q + 32'd1;
   end

   // Edge capture: W1C, but a new rising edge on the same bit wins.
   always_comb begin
      sw_edge_d = sw_edge_q;
      if (wr_sw_edge) begin
         sw_edge_d = sw_edge_d & ~writedata[SW_W-1:0];
      end
      sw_edge_d = sw_edge_d | sw_rise;
   end

   // Timer count: match, reload or increment; software write wins.
   always_comb begin
      tmr_match = tctrl_q.en && (tcnt_q == tcmp_q);
      tcnt_d    = tcnt_q;
      if (tctrl_q.en) begin
         if (tmr_match && tctrl_q.autoreload) begin
            tcnt_d = 32'h0;
         end else begin
            tcnt_d = tcnt_q + 32'd1;
         end
      end
      if (wr_tcnt) begin
         tcnt_d = writedata;
      end
   end

   // Timer control: PEND is W1C, and a match on the same edge wins.
   always_comb begin
      tctrl_d = tctrl_q;
      if (wr_tctrl) begin
         tctrl_d.en         = writedata[TCTRL_EN];
         tctrl_d.autoreload = writedata[TCTRL_AUTO];
         tctrl_d.irq_en     = writedata[TCTRL_IRQ_EN];
         if (writedata[TCTRL_PEND]) begin
            tctrl_d.pend = 1'b0;
         end
      end
      if (tmr_match) begin
         tctrl_d.pend = 1'b1;
      end
   end

   // All responder state; reset discards any write at that edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         led_q     <= '0;
         sw_edge_q <= '0;
         cycle_q   <= 32'h0;
         tcmp_q    <= TCMP_RESET;
         tcnt_q    <= 32'h0;
         tctrl_q   <= '0;
      end else begin
         led_q     <= led_d;
         sw_edge_q <= sw_edge_d;
         cycle_q   <= cycle_d;
         tcmp_q    <= tcmp_d;
         tcnt_q    <= tcnt_d;
         tctrl_q   <= tctrl_d;
      end
   end

   assign led_output = led_q;
   assign irq        = tctrl_q.pend & tctrl_q.irq_en;

endmodule
